// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the register-file write-back path
package mips_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_DEPTH = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;
  localparam int WR_COUNT_W = 16;

  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam wr_count_t WR_COUNT_MAX = '1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting after the last winner
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // Walk last+1, last+2, ... modulo N and grant the first active request
  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin sharing of the register-file write port
module rf_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH,
  parameter int Addres_depth = ADDR_DEPTH,
  parameter int NREQ         = 2
) (
  input  logic                         clk,
  input  logic                         RST,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*Addres_depth-1:0] req_addr,
  input  logic [NREQ*DataWidth-1:0]    req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         hold,
  output logic                         WE3,
  output logic [Addres_depth-1:0]      A3,
  output logic [DataWidth-1:0]         WD3,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  output logic [WR_COUNT_W-1:0]        wr_count
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0]           last;
  logic [NREQ-1:0]         grant;
  logic [GW-1:0]           gidx;
  logic                    xfer;
  logic [Addres_depth-1:0] sel_addr;
  logic [DataWidth-1:0]    sel_data;
  logic                    sel_nonzero;

  // Grants are blocked during reset and hazard freeze
  rr_arbiter #(
    .N  (NREQ),
    .IW (GW)
  ) u_rr (
    .req       (req_valid),
    .last      (last),
    .en        (!hold && !RST),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready   = grant;
  assign xfer        = |(grant & req_valid);
  assign sel_addr    = req_addr[gidx*Addres_depth +: Addres_depth];
  assign sel_data    = req_data[gidx*DataWidth +: DataWidth];
  assign sel_nonzero = (sel_addr != Addres_depth'(ZERO_REG));

  // Register the winning write onto the port; $zero writes complete but never assert WE3
  always_ff @(posedge clk) begin
    if (RST) begin
      last     <= GW'(NREQ - 1);
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      grant_id <= '0;
      wr_count <= '0;
    end else if (xfer) begin
      last     <= gidx;
      A3       <= sel_addr;
      WD3      <= sel_data;
      grant_id <= gidx;
      WE3      <= sel_nonzero;
      if (sel_nonzero && (wr_count != WR_COUNT_MAX)) begin
        wr_count <= wr_count + WR_COUNT_W'(1);
      end
    end else begin
      WE3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  localparam int DW = 32;
  localparam int AD = 5;
  localparam int NREQ = 2;

  logic               clk = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AD-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               hold;
  logic               WE3;
  logic [AD-1:0]      A3;
  logic [DW-1:0]      WD3;
  logic [0:0]         grant_id;
  logic [15:0]        wr_count;

  int errors = 0;
  int checks = 0;

  int          m_last;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd3;
  logic [0:0]  m_gid;
  logic [15:0] m_cnt;

  logic [1:0] rdy_obs, rdy_exp;
  logic       we_pre;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DataWidth(DW), .Addres_depth(AD), .NREQ(NREQ)) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .WE3       (WE3),
    .A3        (A3),
    .WD3       (WD3),
    .grant_id  (grant_id),
    .wr_count  (wr_count)
  );

  function automatic logic [1:0] model_ready(input logic [1:0] v, input logic h, input logic r);
    if (r || h) return 2'b00;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_last + k) % NREQ;
      if (v[idx]) return 2'(1 << idx);
    end
    return 2'b00;
  endfunction

  task automatic cycle(input logic [1:0] v, input logic [9:0] a, input logic [63:0] d,
                       input logic h, input logic r);
    int i;
    @(negedge clk);
    req_valid = v; req_addr = a; req_data = d; hold = h; RST = r;
    #1;
    rdy_obs = req_ready;
    we_pre  = WE3;
    rdy_exp = model_ready(v, h, r);
    @(posedge clk);
    if (r) begin
      m_last = NREQ - 1; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_gid = '0; m_cnt = '0;
    end else if (rdy_exp != 2'b00) begin
      i = rdy_exp[1] ? 1 : 0;
      m_last = i;
      m_gid  = 1'(i);
      m_a3   = a[i*AD +: AD];
      m_wd3  = d[i*DW +: DW];
      m_we   = (m_a3 != 5'd0);
      if (m_we && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      cycle(2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, 1'b0, 1'b1);
      checks++; if (rdy_obs !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", rdy_obs); end
    end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b want 0", WE3); end
    checks++; if (A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %h want 0", A3); end
    checks++; if (WD3 !== 32'd0) begin errors++; $display("FAIL reset_wd3: got %h want 0", WD3); end
    checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_gid: got %b want 0", grant_id); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", wr_count); end
    cycle(2'b11, {5'd7, 5'd0}, {32'h77, 32'h70}, 1'b0, 1'b0);
    checks++; if (rdy_obs !== 2'b01) begin errors++; $display("FAIL first_grant: got %b want 01", rdy_obs); end
    checks++; if (WE3 !== 1'b0 || wr_count !== 16'd0) begin errors++; $display("FAIL first_zero: we=%b cnt=%0d want 0/0", WE3, wr_count); end
  endtask

  task automatic test_single();
    cycle(2'b01, {5'd0, 5'd8}, {32'h0, 32'hDEADBEEF}, 1'b0, 1'b0);
    checks++; if (rdy_obs !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", rdy_obs); end
    checks++; if (WE3 !== 1'b1 || A3 !== 5'd8 || WD3 !== 32'hDEADBEEF || grant_id !== 1'b0)
      begin errors++; $display("FAIL single_port: got we=%b a3=%0d wd3=%h gid=%b want 1/8/deadbeef/0", WE3, A3, WD3, grant_id); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", wr_count); end
    cycle(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (WE3 !== 1'b0 || A3 !== 5'd8 || WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold: got we=%b a3=%0d wd3=%h want 0/8/deadbeef", WE3, A3, WD3); end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 8; c++) begin
      cycle(2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, 1'b0, 1'b0);
      // last winner was requester 0, so the sequence starts at 1
      checks++; if (rdy_obs !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_ready[%0d]: got %b", c, rdy_obs); end
      checks++; if (WE3 !== 1'b1 || A3 !== ((c % 2 == 0) ? 5'd4 : 5'd3) || WD3 !== m_wd3 || grant_id !== m_gid)
        begin errors++; $display("FAIL cont_port[%0d]: got we=%b a3=%0d wd3=%h gid=%b want a3=%0d", c, WE3, A3, WD3, grant_id, m_a3); end
    end
    checks++; if (wr_count !== 16'd9) begin errors++; $display("FAIL cont_cnt: got %0d want 9", wr_count); end
  endtask

  task automatic test_zero();
    cycle(2'b10, {5'd0, 5'd6}, {32'hFFFFFFFF, 32'h5}, 1'b0, 1'b0);
    checks++; if (rdy_obs !== 2'b10) begin errors++; $display("FAIL zero_ready: got %b want 10", rdy_obs); end
    checks++; if (WE3 !== 1'b0 || wr_count !== 16'd9) begin errors++; $display("FAIL zero_port: we=%b cnt=%0d want 0/9", WE3, wr_count); end
    cycle(2'b11, {5'd2, 5'd6}, {32'hB, 32'hA}, 1'b0, 1'b0);
    checks++; if (rdy_obs !== 2'b01) begin errors++; $display("FAIL zero_next: got %b want 01", rdy_obs); end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 3; c++) begin
      cycle(2'b11, {5'd2, 5'd6}, {32'hB, 32'hA}, 1'b1, 1'b0);
      checks++; if (rdy_obs !== 2'b00) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 00", c, rdy_obs); end
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL hold_we3[%0d]: got %b want 0", c, WE3); end
    end
    cycle(2'b11, {5'd2, 5'd6}, {32'hB, 32'hA}, 1'b0, 1'b0);
    checks++; if (rdy_obs !== 2'b10) begin errors++; $display("FAIL hold_resume: got %b want 10", rdy_obs); end
    checks++; if (WE3 !== 1'b1 || A3 !== 5'd2 || grant_id !== 1'b1) begin errors++; $display("FAIL hold_port: we=%b a3=%0d gid=%b want 1/2/1", WE3, A3, grant_id); end
  endtask

  task automatic test_reset_midstream();
    cycle(2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 1'b0, 1'b0);
    cycle(2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, 1'b0, 1'b1);
    checks++; if (we_pre !== 1'b1 || rdy_obs !== 2'b00) begin errors++; $display("FAIL rst_mid_pre: we=%b rdy=%b want 1/00", we_pre, rdy_obs); end
    checks++; if (WE3 !== 1'b0 || wr_count !== 16'd0 || A3 !== 5'd0) begin errors++; $display("FAIL rst_mid_post: we=%b cnt=%0d a3=%0d want 0/0/0", WE3, wr_count, A3); end
  endtask

  task automatic test_random();
    logic [1:0]  v;
    logic [9:0]  a;
    logic [63:0] d;
    logic        h;
    int          wait_cnt [NREQ];
    v = '0; a = '0; d = '0;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i]) begin
          v[i] = ($urandom_range(0, 3) != 0);
          a[i*AD +: AD] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
          d[i*DW +: DW] = $urandom;
        end
      end
      h = ($urandom_range(0, 7) == 0);
      cycle(v, a, d, h, 1'b0);
      checks++; if (rdy_obs !== rdy_exp) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, rdy_obs, rdy_exp); end
      checks++; if (WE3 !== m_we || A3 !== m_a3 || WD3 !== m_wd3 || grant_id !== m_gid || wr_count !== m_cnt)
        begin errors++; $display("FAIL rnd_port[%0d]: got %b/%0d/%h/%b/%0d want %b/%0d/%h/%b/%0d", c, WE3, A3, WD3, grant_id, wr_count, m_we, m_a3, m_wd3, m_gid, m_cnt); end
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && rdy_exp[i]) begin v[i] = 1'b0; wait_cnt[i] = 0; end
        else if (v[i] && !h) wait_cnt[i]++;
        checks++; if (wait_cnt[i] >= NREQ) begin errors++; $display("FAIL rnd_starve[%0d]: req %0d waited %0d", c, i, wait_cnt[i]); end
      end
    end
  endtask

  task automatic test_saturation();
    int guard;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cycle(2'b01, {5'd0, 5'd1}, {32'h0, 32'h1}, 1'b0, 1'b0);
      guard++;
    end
    checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", wr_count); end
    for (int c = 0; c < 2; c++) begin
      cycle(2'b01, {5'd0, 5'd1}, {32'h0, 32'h1}, 1'b0, 1'b0);
      checks++; if (wr_count !== 16'hFFFF || WE3 !== 1'b1) begin errors++; $display("FAIL sat_hold[%0d]: cnt=%h we=%b want ffff/1", c, wr_count, WE3); end
    end
  endtask

  initial begin
    RST = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    m_last = NREQ - 1; m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_gid = '0; m_cnt = '0;
    test_reset();
    test_single();
    test_contention();
    test_zero();
    test_hold();
    test_reset_midstream();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that shares the register file's single write port (WE3/A3/WD3) among NREQ requesters, e.g. ALU write-back and load write-back. Requests use a valid/ready handshake. Grants are round-robin, and the winning write is registered into the port one cycle later. Writes to register 0 ($zero) are acknowledged but suppressed. The block sits between the execute/memory write-back sources and the register file.

## Interface
Parameters:
- DataWidth, 32, width of write data
- Addres_depth, 5, width of register address
- NREQ, 2, number of requesters (≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- RST  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*Addres_depth  packed destination addresses; requester i at [i*Addres_depth +: Addres_depth]
- req_data  in  NREQ*DataWidth  packed write data; requester i at [i*DataWidth +: DataWidth]
- req_ready  out  NREQ  one-hot-or-zero grant; transfer i occurs when req_valid[i] && req_ready[i] at a rising edge
- hold  in  1  hazard-unit freeze; blocks all grants
- WE3  out  1  register-file write enable (registered)
- A3  out  Addres_depth  register-file write address (registered)
- WD3  out  DataWidth  register-file write data (registered)
- grant_id  out  $clog2(NREQ)  index of requester whose write is on the port (valid when WE3=1)
- wr_count  out  16  count of committed non-zero-address writes, saturating at 0xFFFF

## Operation
Arbitration:
- The pointer `last` holds the index of the most recently granted requester.
- The search order is last+1, last+2, … modulo NREQ.
- The first requester with req_valid=1 in that order gets req_ready=1. All other ready bits are 0.

Blocking conditions:
- req_ready is combinational from req_valid, `last`, hold and RST.
- If hold=1 or RST=1, req_ready is all zero.
- A requester that is not granted must keep valid/addr/data stable until it is granted.

On a transfer by requester i:
- `last` takes the value i.
- A3 takes req_addr[i]. WD3 takes req_data[i]. grant_id takes i.
- WE3 takes 1 if req_addr[i] != 0, otherwise 0.
- If WE3 is set, wr_count increments, holding at 0xFFFF once saturated.

Other cases:
- With no transfer, WE3 takes 0. A3, WD3 and grant_id hold their values.
- If the address is 0, the transfer still completes and `last` still advances. No write occurs and wr_count is unchanged.
- A single requester with continuous valid is granted every cycle (full throughput).

Reset takes priority over everything:
- WE3=0, A3=0, WD3=0, grant_id=0, wr_count=0.
- last=NREQ-1, so requester 0 wins first after reset.
- A request asserted during a RST cycle is not accepted.
- A write already on the port in the cycle when RST is sampled is still performed by the register file at that edge. WE3 is then 0 from the following cycle.

## Timing
- Latency: transfer at edge N puts WE3/A3/WD3 valid throughout cycle N+1. The register file commits at edge N+1.
- Back-to-back grants to alternating requesters produce WE3=1 every cycle. There are no bubbles between writes.
- hold asserted in cycle N means no transfer at edge N, so WE3=0 in cycle N+1. The pointer is unchanged.
- hold and RST do not affect a write already registered on the port.
- Simultaneous valid from all requesters: exactly one grant per cycle, rotating. Each requester is served within NREQ cycles (starvation-free).
- The arbiter does not forward write data to read ports. Read-after-write bypass is the hazard unit's job.

## Structure
- Shared package `mips_pkg` holds:
  - default DataWidth=32 and Addres_depth=5;
  - ZERO_REG = 5'd0;
  - the wr_count width constant (16).
- Sub-module `rr_arbiter` #(N): inputs are req vector, last index and enable. Outputs are a one-hot grant and the grant index. It is purely combinational.
- The top level holds the pointer, the output registers, the address-0 suppression and wr_count.

## Test plan
- Reset: assert RST for 2 cycles with req_valid=2'b11 → req_ready=0 during reset. After reset, all outputs are 0 and the first grant is requester 0.
- Single write: req0 addr=5'd8, data=32'hDEADBEEF for one cycle → req_ready[0]=1. In the next cycle WE3=1, A3=8, WD3=DEADBEEF, grant_id=0, and wr_count becomes 1.
- Contention: both valid continuously, req0 (addr 3, data 0x11), req1 (addr 4, data 0x22) → grants alternate 0,1,0,1. WE3 stays 1 every cycle, with A3 alternating 3,4.
- Zero register: req1 addr=0, data=0xFFFFFFFF → req_ready[1]=1 and WE3=0 in the next cycle. wr_count is unchanged and the next grant goes to requester 0.
- Hold: hold=1 for 3 cycles with both valid → req_ready=0 and WE3=0 for 3 cycles. After release, the grant resumes at the pointer's next index.
- Saturation: preload wr_count by 65535 writes, then issue 2 more → wr_count stays at 0xFFFF.
